mem_access_unit: RTL and testbench

- MEM-stage data-memory responder. Consumes the registered memory request from the EXE/MEM pipeline register (op, address, store data) and drives a synchronous word-wide RAM with byte write enables.
- Performs byte/halfword/word loads and stores, with little-endian lane steering and sign/zero extension.
- Stalls the pipeline for the RAM read latency and flags misaligned accesses.

---
 rtl/mem_access_unit.sv | 89 ++++++++
 tb/tb_mem_access_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory responder driving a synchronous RAM with byte enables,
// lane steering, sign/zero extension, read-latency stall and misalignment flagging.
module mem_access_unit #(
    parameter int ADDR_W       = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_op,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_data,
    output logic              ram_en,
    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              misalign_exc,
    output logic [31:0]       bad_addr
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4, LW = 4'd5;
    localparam logic [3:0] SB = 4'd6, SH = 4'd7, SW = 4'd8;

    state_t      state, state_nx;
    logic [1:0]  cnt, off_q;
    logic [3:0]  op_q, wea_sel;
    logic        is_load, is_store, misalign, idle_miss;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ext, wdata_sel;

    always_comb begin
        is_load   = mem_op >= LB && mem_op <= LW;
        is_store  = mem_op >= SB && mem_op <= SW;
        misalign  = ((mem_op == LH || mem_op == LHU || mem_op == SH) && mem_addr[0]) ||
                    ((mem_op == LW || mem_op == SW) && mem_addr[1:0] != 2'b00);
        idle_miss = state == IDLE && misalign;
        wea_sel   = mem_op == SB ? 4'b0001 << mem_addr[1:0] :
                    mem_op == SH ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_sel = mem_op == SB ? {4{mem_data[7:0]}} :
                    mem_op == SH ? {2{mem_data[15:0]}} : mem_data;
        ram_en    = state == IDLE && (is_load || is_store) && !misalign;
        ram_wea   = ram_en && is_store ? wea_sel : 4'b0000;
        ram_wdata = ram_en && is_store ? wdata_sel : 32'h0;
        ram_addr  = ram_en ? mem_addr[ADDR_W+1:2] : '0;
        stall     = (ram_en && is_load) || state == WAIT;
        load_valid = state == RESP;
        state_nx  = state == IDLE ? (ram_en && is_load ? WAIT : IDLE) :
                    state == WAIT ? (cnt == 2'd0 ? RESP : WAIT) : IDLE;
    end

    // Lane extraction uses the offset latched at issue, not the live request.
    always_comb begin
        rbyte = ram_rdata[{off_q, 3'b000} +: 8];
        rhalf = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        ext   = op_q == LB  ? {{24{rbyte[7]}}, rbyte} :
                op_q == LBU ? {24'h0, rbyte} :
                op_q == LH  ? {{16{rhalf[15]}}, rhalf} :
                op_q == LHU ? {16'h0, rhalf} : ram_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            op_q         <= 4'd0;
            off_q        <= 2'd0;
            load_data    <= 32'h0;
            bad_addr     <= 32'h0;
            misalign_exc <= 1'b0;
        end else begin
            state        <= state_nx;
            misalign_exc <= idle_miss;
            if (idle_miss)
                bad_addr <= mem_addr;
            if (state == IDLE) begin
                op_q  <= mem_op;
                off_q <= mem_addr[1:0];
                cnt   <= 2'(READ_LATENCY - 1);
            end else if (state == WAIT && cnt != 2'd0)
                cnt <= cnt - 2'd1;
            if (state == WAIT && cnt == 2'd0)
                load_data <= ext;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of stores, loads, latency, misalignment and reset
// on two instances (read latency 1 and 3) each backed by a small behavioural RAM.
module tb_mem_access_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  mem_op = 4'd0;
    logic [31:0] mem_addr = 32'h0, mem_data = 32'h0;
    logic        en1, st1, lv1, mx1, en3, st3, lv3, mx3;
    logic [3:0]  wea1, wea3;
    logic [13:0] addr1, addr3;
    logic [31:0] wd1, rd1, ld1, ba1, wd3, rd3, ld3, ba3;
    logic [31:0] m1 [64];
    logic [31:0] m3 [64];
    logic [31:0] p3 [3];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(14), .READ_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .mem_op(mem_op), .mem_addr(mem_addr), .mem_data(mem_data),
        .ram_en(en1), .ram_wea(wea1), .ram_addr(addr1), .ram_wdata(wd1), .ram_rdata(rd1),
        .stall(st1), .load_valid(lv1), .load_data(ld1), .misalign_exc(mx1), .bad_addr(ba1));

    mem_access_unit #(.ADDR_W(14), .READ_LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .mem_op(mem_op), .mem_addr(mem_addr), .mem_data(mem_data),
        .ram_en(en3), .ram_wea(wea3), .ram_addr(addr3), .ram_wdata(wd3), .ram_rdata(rd3),
        .stall(st3), .load_valid(lv3), .load_data(ld3), .misalign_exc(mx3), .bad_addr(ba3));

    always @(posedge clk) begin
        if (en1) begin
            for (int i = 0; i < 4; i++)
                if (wea1[i]) m1[addr1[5:0]][8*i +: 8] <= wd1[8*i +: 8];
            rd1 <= m1[addr1[5:0]];
        end
    end

    always @(posedge clk) begin
        if (en3)
            for (int i = 0; i < 4; i++)
                if (wea3[i]) m3[addr3[5:0]][8*i +: 8] <= wd3[8*i +: 8];
        p3[0] <= m3[addr3[5:0]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd3 = p3[2];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (en1 !== 1'b0) begin bad++; $display("FAIL reset_ram_en got=%0h exp=0", en1); end
        total++; if (wea1 !== 4'h0) begin bad++; $display("FAIL reset_wea got=%0h exp=0", wea1); end
        total++; if (st1 !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", st1); end
        total++; if (lv1 !== 1'b0) begin bad++; $display("FAIL reset_load_valid got=%0h exp=0", lv1); end
        total++; if (ld1 !== 32'h0) begin bad++; $display("FAIL reset_load_data got=%0h exp=0", ld1); end
        total++; if (mx1 !== 1'b0 || ba1 !== 32'h0) begin bad++; $display("FAIL reset_misalign got=%0h/%0h exp=0/0", mx1, ba1); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_stores();
        mem_op = 4'd8; mem_addr = 32'h10; mem_data = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (en1 !== 1'b1) begin bad++; $display("FAIL sw_en got=%0h exp=1", en1); end
        total++; if (wea1 !== 4'hF) begin bad++; $display("FAIL sw_wea got=%0h exp=f", wea1); end
        total++; if (addr1 !== 14'd4) begin bad++; $display("FAIL sw_addr got=%0h exp=4", addr1); end
        total++; if (wd1 !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%0h exp=deadbeef", wd1); end
        total++; if (st1 !== 1'b0) begin bad++; $display("FAIL sw_stall got=%0h exp=0", st1); end
        next_cycle();
        mem_op = 4'd6; mem_addr = 32'h13; mem_data = 32'h000000A5;
        @(negedge clk);
        total++; if (wea1 !== 4'b1000) begin bad++; $display("FAIL sb_wea got=%0h exp=8", wea1); end
        total++; if (wd1 !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%0h exp=a5a5a5a5", wd1); end
        next_cycle();
        mem_op = 4'd7; mem_addr = 32'h12; mem_data = 32'h00001234;
        @(negedge clk);
        total++; if (wea1 !== 4'b1100) begin bad++; $display("FAIL sh_wea got=%0h exp=c", wea1); end
        total++; if (wd1 !== 32'h12341234) begin bad++; $display("FAIL sh_wdata got=%0h exp=12341234", wd1); end
        next_cycle();
        mem_op = 4'd8; mem_addr = 32'h20; mem_data = 32'h80FF7F01;
        @(negedge clk);
        total++; if (en1 !== 1'b1 || addr1 !== 14'd8) begin bad++; $display("FAIL sw2_en got=%0h/%0h exp=1/8", en1, addr1); end
        next_cycle();
        mem_op = 4'd0;
        next_cycle();
    endtask

    task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] exp, input string name);
        mem_op = op; mem_addr = addr;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (st1 !== (c < 2) || lv1 !== (c == 2)) begin
                bad++; $display("FAIL %s_timing c=%0d got stall=%0h valid=%0h", name, c, st1, lv1);
            end
            if (c == 2) begin
                total++; if (ld1 !== exp) begin bad++; $display("FAIL %s_data got=%0h exp=%0h", name, ld1, exp); end
            end
            next_cycle();
        end
        mem_op = 4'd0;
    endtask

    task automatic test_loads();
        do_load(4'd1, 32'h22, 32'hFFFFFFFF, "lb2");
        do_load(4'd2, 32'h23, 32'h00000080, "lbu3");
        do_load(4'd3, 32'h22, 32'hFFFF80FF, "lh2");
        do_load(4'd5, 32'h20, 32'h80FF7F01, "lw");
        do_load(4'd4, 32'h20, 32'h00007F01, "lhu0");
        do_load(4'd1, 32'h21, 32'h0000007F, "lb1");
    endtask

    task automatic test_latency3();
        mem_op = 4'd0;
        repeat (6) next_cycle();
        mem_op = 4'd5; mem_addr = 32'h20;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) mem_op = 4'd0;
            @(negedge clk);
            total++;
            if (st3 !== (c <= 3) || lv3 !== (c == 4)) begin
                bad++; $display("FAIL rl3_timing c=%0d got stall=%0h valid=%0h", c, st3, lv3);
            end
            if (c == 4) begin
                total++; if (ld3 !== 32'h80FF7F01) begin bad++; $display("FAIL rl3_data got=%0h exp=80ff7f01", ld3); end
            end
            next_cycle();
        end
    endtask

    task automatic test_misalign(input logic [3:0] op, input logic [31:0] addr, input string name);
        mem_op = op; mem_addr = addr;
        @(negedge clk);
        total++; if (en1 !== 1'b0 || st1 !== 1'b0 || wea1 !== 4'h0) begin bad++; $display("FAIL %s_noaccess got en=%0h stall=%0h wea=%0h", name, en1, st1, wea1); end
        total++; if (mx1 !== 1'b0) begin bad++; $display("FAIL %s_early got=%0h exp=0", name, mx1); end
        next_cycle();
        mem_op = 4'd0;
        @(negedge clk);
        total++; if (mx1 !== 1'b1 || ba1 !== addr) begin bad++; $display("FAIL %s_exc got=%0h/%0h exp=1/%0h", name, mx1, ba1, addr); end
        next_cycle();
        @(negedge clk);
        total++; if (mx1 !== 1'b0 || ba1 !== addr) begin bad++; $display("FAIL %s_pulse got=%0h/%0h exp=0/%0h", name, mx1, ba1, addr); end
        next_cycle();
    endtask

    task automatic test_reset_mid_load();
        mem_op = 4'd5; mem_addr = 32'h20;
        @(negedge clk);
        total++; if (st1 !== 1'b1) begin bad++; $display("FAIL rmid_issue got=%0h exp=1", st1); end
        next_cycle();
        @(negedge clk);
        total++; if (st1 !== 1'b1 || lv1 !== 1'b0) begin bad++; $display("FAIL rmid_wait got=%0h/%0h exp=1/0", st1, lv1); end
        #1 rst = 1'b1; mem_op = 4'd0;
        #1;
        total++; if (st1 !== 1'b0 || ld1 !== 32'h0) begin bad++; $display("FAIL rmid_clear got=%0h/%0h exp=0/0", st1, ld1); end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (lv1 !== 1'b0) begin bad++; $display("FAIL rmid_novalid c=%0d got=%0h exp=0", c, lv1); end
            next_cycle();
        end
        do_load(4'd5, 32'h20, 32'h80FF7F01, "lw_after_rst");
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_latency3();
        test_misalign(4'd5, 32'h102, "lw_mis");
        test_misalign(4'd7, 32'h1, "sh_mis");
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
